// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : draw_pkg
//  Description : Shared types, sprite geometry and colours for the sprite renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
package draw_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SNAP  = 3'd1,
        S_ERASE = 3'd2,
        S_DRAW  = 3'd3,
        S_DONE  = 3'd4
    } draw_state_t;

    localparam int c_screen_w_dflt = 640;
    localparam int c_screen_h_dflt = 480;
    localparam int c_num_obj       = 4;

    localparam logic [1:0] c_obj_m1    = 2'd0;
    localparam logic [1:0] c_obj_m2    = 2'd1;
    localparam logic [1:0] c_obj_lava  = 2'd2;
    localparam logic [1:0] c_obj_plane = 2'd3;

    localparam logic [2:0] c_col_bg       = 3'b000;
    localparam logic [2:0] c_col_plane    = 3'b111;
    localparam logic [2:0] c_col_plane_go = 3'b110;
    localparam logic [2:0] c_col_lava     = 3'b100;
    localparam logic [2:0] c_col_mountain = 3'b010;

    localparam logic [4:0] c_mtn_w   = 5'd16;
    localparam logic [4:0] c_mtn_h   = 5'd16;
    localparam logic [4:0] c_lava_w  = 5'd8;
    localparam logic [4:0] c_lava_h  = 5'd8;
    localparam logic [4:0] c_plane_w = 5'd16;
    localparam logic [4:0] c_plane_h = 5'd8;

    function automatic logic [4:0] sprite_w(input logic [1:0] obj);
        case (obj)
            c_obj_lava:  return c_lava_w;
            c_obj_plane: return c_plane_w;
            default:     return c_mtn_w;
        endcase
    endfunction

    function automatic logic [4:0] sprite_h(input logic [1:0] obj);
        case (obj)
            c_obj_lava:  return c_lava_h;
            c_obj_plane: return c_plane_h;
            default:     return c_mtn_h;
        endcase
    endfunction

    function automatic logic [2:0] sprite_colour(input logic [1:0] obj, input logic go);
        case (obj)
            c_obj_lava:  return c_col_lava;
            c_obj_plane: return go ? c_col_plane_go : c_col_plane;
            default:     return c_col_mountain;
        endcase
    endfunction

    // Lowest valid object index at or above 'from'; bit 2 flags that one exists.
    function automatic logic [2:0] first_valid(input logic [3:0] valid, input logic [2:0] from);
        logic [2:0] sel;
        sel = 3'b000;
        for (int i = c_num_obj - 1; i >= 0; i--) begin
            if (valid[i] && (3'(i) >= from)) begin
                sel = {1'b1, 2'(i)};
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rect_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : rect_scanner
//  Description : Row-major dx/dy walker over a W x H rectangle with stall control.
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_scanner (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_start,
    input  logic       i_advance,
    input  logic [4:0] i_w,
    input  logic [4:0] i_h,
    output logic [4:0] o_dx,
    output logic [4:0] o_dy,
    output logic       o_last
);

    logic [4:0] r_dx;
    logic [4:0] r_dy;
    logic       w_row_end;

    assign w_row_end = (r_dx == i_w - 5'd1);
    assign o_last    = w_row_end && (r_dy == i_h - 5'd1);
    assign o_dx      = r_dx;
    assign o_dy      = r_dy;

    // Wrapping to 0,0 after the last pixel lets the next rectangle start without a restart.
    always_ff @(posedge clk) begin
        if (!resetn || i_start) begin
            r_dx <= '0;
            r_dy <= '0;
        end else if (i_advance) begin
            if (w_row_end) begin
                r_dx <= '0;
                r_dy <= o_last ? 5'd0 : r_dy + 5'd1;
            end else begin
                r_dx <= r_dx + 5'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_renderer
//  Description : Per-frame erase/redraw of four sprites into a handshaked pixel stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_renderer
    import draw_pkg::*;
#(
    parameter int PLANE_X  = 40,
    parameter int SCREEN_W = c_screen_w_dflt,
    parameter int SCREEN_H = c_screen_h_dflt
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       game_over,
    input  logic [9:0] plane_y,
    input  logic [9:0] lava_x,
    input  logic [9:0] lava_y,
    input  logic [9:0] mountain1_x,
    input  logic [9:0] mountain1_y,
    input  logic [9:0] mountain2_x,
    input  logic [9:0] mountain2_y,
    input  logic       pix_ready,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_drop
);

    draw_state_t r_state;
    draw_state_t w_state_nxt;
    logic [1:0]  r_obj;
    logic [1:0]  w_obj_nxt;

    logic [9:0]  r_snap_x [c_num_obj];
    logic [9:0]  r_snap_y [c_num_obj];
    logic [9:0]  r_old_x  [c_num_obj];
    logic [9:0]  r_old_y  [c_num_obj];
    logic [3:0]  r_valid;
    logic        r_go;

    logic [4:0]  w_w;
    logic [4:0]  w_h;
    logic [4:0]  w_dx;
    logic [4:0]  w_dy;
    logic        w_last;
    logic        w_snap;
    logic        w_erase;
    logic        w_scanning;
    logic        w_clip;
    logic        w_advance;
    logic        w_obj_done;
    logic [9:0]  w_base_x;
    logic [9:0]  w_base_y;
    logic [10:0] w_px;
    logic [10:0] w_py;
    logic [2:0]  w_from;
    logic [2:0]  w_sel;

    assign w_snap     = (r_state == S_SNAP);
    assign w_erase    = (r_state == S_ERASE);
    assign w_scanning = w_erase || (r_state == S_DRAW);

    assign w_base_x = w_erase ? r_old_x[r_obj] : r_snap_x[r_obj];
    assign w_base_y = w_erase ? r_old_y[r_obj] : r_snap_y[r_obj];
    assign w_px     = {1'b0, w_base_x} + {6'd0, w_dx};
    assign w_py     = {1'b0, w_base_y} + {6'd0, w_dy};

    // Off-screen slots burn one cycle without waiting for the adapter.
    assign w_clip     = (w_px >= 11'(SCREEN_W)) || (w_py >= 11'(SCREEN_H));
    assign w_advance  = w_scanning && (w_clip || pix_ready);
    assign w_obj_done = w_advance && w_last;

    assign w_w = sprite_w(r_obj);
    assign w_h = sprite_h(r_obj);

    // Erase skips invalid objects in zero cycles by jumping straight to the next valid one.
    assign w_from = w_snap ? 3'd0 : ({1'b0, r_obj} + 3'd1);
    assign w_sel  = first_valid(r_valid, w_from);

    rect_scanner u_scan (
        .clk       (clk),
        .resetn    (resetn),
        .i_start   (w_snap),
        .i_advance (w_advance),
        .i_w       (w_w),
        .i_h       (w_h),
        .o_dx      (w_dx),
        .o_dy      (w_dy),
        .o_last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_obj   <= c_obj_m1;
        end else begin
            r_state <= w_state_nxt;
            r_obj   <= w_obj_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_obj_nxt   = r_obj;
        x           = '0;
        y           = '0;
        colour      = c_col_bg;
        plot        = 1'b0;
        busy        = (r_state != S_IDLE);
        frame_done  = 1'b0;
        frame_drop  = frame_tick && (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (frame_tick) begin
                    w_state_nxt = S_SNAP;
                end
            end
            S_SNAP, S_ERASE: begin
                if (w_snap || w_obj_done) begin
                    if (w_sel[2]) begin
                        w_state_nxt = S_ERASE;
                        w_obj_nxt   = w_sel[1:0];
                    end else begin
                        w_state_nxt = S_DRAW;
                        w_obj_nxt   = c_obj_m1;
                    end
                end
            end
            S_DRAW: begin
                if (w_obj_done) begin
                    if (r_obj == c_obj_plane) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_obj_nxt = r_obj + 2'd1;
                    end
                end
            end
            S_DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_scanning) begin
            x      = w_px[9:0];
            y      = w_py[8:0];
            colour = w_erase ? c_col_bg : sprite_colour(r_obj, r_go);
            plot   = !w_clip;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < c_num_obj; i++) begin
                r_snap_x[i] <= '0;
                r_snap_y[i] <= '0;
                r_old_x[i]  <= '0;
                r_old_y[i]  <= '0;
            end
            r_valid <= '0;
            r_go    <= 1'b0;
        end else begin
            if (w_snap) begin
                r_snap_x[c_obj_m1]    <= mountain1_x;
                r_snap_y[c_obj_m1]    <= mountain1_y;
                r_snap_x[c_obj_m2]    <= mountain2_x;
                r_snap_y[c_obj_m2]    <= mountain2_y;
                r_snap_x[c_obj_lava]  <= lava_x;
                r_snap_y[c_obj_lava]  <= lava_y;
                r_snap_x[c_obj_plane] <= 10'(PLANE_X);
                r_snap_y[c_obj_plane] <= plane_y;
                r_go                  <= game_over;
            end
            // The shadow copy becomes next frame's erase rectangle.
            if ((r_state == S_DRAW) && w_obj_done) begin
                r_old_x[r_obj] <= r_snap_x[r_obj];
                r_old_y[r_obj] <= r_snap_y[r_obj];
                r_valid[r_obj] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_renderer
//  Description : Self-checking bench for sprite_renderer against a pixel-list model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_renderer;

    typedef logic [21:0] pix_t;

    logic       clk = 1'b0;
    logic       resetn, frame_tick, game_over, pix_ready;
    logic [9:0] plane_y, lava_x, lava_y, mountain1_x, mountain1_y, mountain2_x, mountain2_y;
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] colour;
    logic       plot, busy, frame_done, frame_drop;

    sprite_renderer dut (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .game_over(game_over),
        .plane_y(plane_y), .lava_x(lava_x), .lava_y(lava_y),
        .mountain1_x(mountain1_x), .mountain1_y(mountain1_y),
        .mountain2_x(mountain2_x), .mountain2_y(mountain2_y),
        .pix_ready(pix_ready), .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .frame_done(frame_done), .frame_drop(frame_drop)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    pix_t exp_q[$];
    pix_t got_q[$];
    int   m_old_x[4], m_old_y[4];
    bit   m_valid[4];
    int   n_acc, first_plot_cyc, last_plot_cyc, done_cyc, done_cnt, drop_cnt, hold_err, stall_cyc;
    bit   busy_at_snap, timed_out;

    function automatic pix_t mk(input int px, input int py, input int c);
        return {10'(px), 9'(py), 3'(c)};
    endfunction

    // Reference model: an ordered list of every on-screen pixel the frame must deliver.
    task automatic push_rect(input int ox, input int oy, input int w, input int h, input int c);
        for (int dy = 0; dy < h; dy++)
            for (int dx = 0; dx < w; dx++)
                if (ox + dx < 640 && oy + dy < 480) exp_q.push_back(mk(ox + dx, oy + dy, c));
    endtask

    task automatic model_frame(input bit go);
        int nx[4], ny[4], w[4], h[4], col[4];
        nx  = '{int'(mountain1_x), int'(mountain2_x), int'(lava_x), 40};
        ny  = '{int'(mountain1_y), int'(mountain2_y), int'(lava_y), int'(plane_y)};
        w   = '{16, 16, 8, 16};
        h   = '{16, 16, 8, 8};
        col = '{2, 2, 4, go ? 6 : 7};
        exp_q.delete();
        for (int o = 0; o < 4; o++)
            if (m_valid[o]) push_rect(m_old_x[o], m_old_y[o], w[o], h[o], 0);
        for (int o = 0; o < 4; o++) begin
            push_rect(nx[o], ny[o], w[o], h[o], col[o]);
            m_old_x[o] = nx[o];
            m_old_y[o] = ny[o];
            m_valid[o] = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < 4; o++) m_valid[o] = 1'b0;
    endtask

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; frame_tick = 1'b0; pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    // mode 0: ready always high, 1: random ready, 2: one 3-cycle stall inside lava draw
    task automatic run_frame(input int mode, input int drop_at, input bit flip_go, input int budget);
        int   lava_acc, stall_left;
        bit   stalled, prev_wait;
        pix_t prev, cur;
        lava_acc = 0; stall_left = 0; stalled = 0; prev_wait = 0; prev = '0;
        got_q.delete();
        n_acc = 0; first_plot_cyc = -1; last_plot_cyc = -1; done_cyc = -1; done_cnt = 0;
        drop_cnt = 0; hold_err = 0; stall_cyc = 0; busy_at_snap = 0; timed_out = 1;
        @(negedge clk);
        frame_tick = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            frame_tick = (cyc == drop_at);
            if (flip_go && cyc == 5) game_over = ~game_over;
            #1;
            if (cyc == 1) busy_at_snap = busy;
            if (frame_drop) drop_cnt++;
            if (frame_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            cur = {x, y, colour};
            if (prev_wait && (!plot || cur !== prev)) hold_err++;
            if (plot) begin
                if (first_plot_cyc < 0) first_plot_cyc = cyc;
                last_plot_cyc = cyc;
            end
            if (mode == 2 && plot && colour == 3'b100 && lava_acc == 10 && !stalled) begin
                stall_left = 3;
                stalled    = 1;
            end
            if (stall_left > 0) begin
                pix_ready = 1'b0;
                stall_left--;
            end else if (mode == 1) pix_ready = ($urandom_range(0, 3) != 0);
            else pix_ready = 1'b1;
            if (plot && pix_ready) begin
                got_q.push_back(cur);
                n_acc++;
                if (colour == 3'b100) lava_acc++;
            end
            if (plot && !pix_ready) stall_cyc++;
            prev_wait = plot && !pix_ready;
            prev      = cur;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) begin
                timed_out = 0;
                break;
            end
        end
        frame_tick = 1'b0;
        pix_ready  = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; frame_tick = 1'b0; game_over = 1'b0; pix_ready = 1'b1;
        plane_y = '0; lava_x = '0; lava_y = '0;
        mountain1_x = '0; mountain1_y = '0; mountain2_x = '0; mountain2_y = '0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if ({x, y, colour, plot, busy, frame_done, frame_drop} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", {x, y, colour, plot, busy, frame_done, frame_drop});
        end
        resetn = 1'b1;
        model_reset();
        @(negedge clk); #1;
        n_vec++;
        if ({plot, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_idle: got plot/busy %b want 00", {plot, busy});
        end
    endtask

    task automatic test_first_frame();
        int d;
        plane_y = 10'd80; lava_x = 10'd300; lava_y = 10'd200;
        mountain1_x = 10'd250; mountain1_y = 10'd100; mountain2_x = 10'd500; mountain2_y = 10'd100;
        model_frame(1'b0);
        run_frame(0, -1, 1'b0, 3000);
        n_vec++; if (timed_out) begin n_err++; $display("FAIL first_timeout: got no frame_done want frame_done"); end
        n_vec++; if (busy_at_snap !== 1'b1) begin n_err++; $display("FAIL first_busy: got %b want 1", busy_at_snap); end
        n_vec++; if (first_plot_cyc != 2) begin n_err++; $display("FAIL first_latency: got %0d want 2", first_plot_cyc); end
        n_vec++; if (n_acc != 704) begin n_err++; $display("FAIL first_count: got %0d want 704", n_acc); end
        n_vec++; if (got_q[0] !== mk(250, 100, 2)) begin n_err++; $display("FAIL first_pixel: got %h want %h", got_q[0], mk(250, 100, 2)); end
        n_vec++; if (got_q[$] !== mk(55, 87, 7)) begin n_err++; $display("FAIL first_last: got %h want %h", got_q[$], mk(55, 87, 7)); end
        n_vec++; if (done_cyc != last_plot_cyc + 1) begin n_err++; $display("FAIL first_done_time: got %0d want %0d", done_cyc, last_plot_cyc + 1); end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL first_done_count: got %0d want 1", done_cnt); end
        d = first_diff();
        n_vec++; if (d >= 0) begin n_err++; $display("FAIL first_seq: at %0d got %h want %h", d, got_q[d], exp_q[d]); end
    endtask

    task automatic test_second_frame();
        int d;
        plane_y = 10'd88;
        model_frame(1'b0);
        run_frame(0, -1, 1'b0, 4000);
        n_vec++; if (n_acc != 1408) begin n_err++; $display("FAIL second_count: got %0d want 1408", n_acc); end
        n_vec++; if (got_q[0] !== mk(250, 100, 0)) begin n_err++; $display("FAIL second_first: got %h want %h", got_q[0], mk(250, 100, 0)); end
        n_vec++; if (got_q[576] !== mk(40, 80, 0)) begin n_err++; $display("FAIL second_plane_erase: got %h want %h", got_q[576], mk(40, 80, 0)); end
        n_vec++; if (got_q[1407] !== mk(55, 95, 7)) begin n_err++; $display("FAIL second_plane_draw: got %h want %h", got_q[1407], mk(55, 95, 7)); end
        d = first_diff();
        n_vec++; if (d >= 0) begin n_err++; $display("FAIL second_seq: at %0d got %h want %h", d, got_q[d], exp_q[d]); end
    endtask

    task automatic test_stall();
        int d;
        model_frame(1'b0);
        run_frame(2, -1, 1'b0, 4000);
        n_vec++; if (stall_cyc != 3) begin n_err++; $display("FAIL stall_cycles: got %0d want 3", stall_cyc); end
        n_vec++; if (hold_err != 0) begin n_err++; $display("FAIL stall_hold: got %0d unstable cycles want 0", hold_err); end
        n_vec++; if (n_acc != 1408) begin n_err++; $display("FAIL stall_count: got %0d want 1408", n_acc); end
        d = first_diff();
        n_vec++; if (d >= 0) begin n_err++; $display("FAIL stall_seq: at %0d got %h want %h", d, got_q[d], exp_q[d]); end
    endtask

    task automatic test_frame_drop();
        int d;
        model_frame(1'b0);
        run_frame(0, 300, 1'b0, 4000);
        n_vec++; if (drop_cnt != 1) begin n_err++; $display("FAIL drop_pulse: got %0d want 1", drop_cnt); end
        n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL drop_done_count: got %0d want 1", done_cnt); end
        d = first_diff();
        n_vec++; if (d >= 0) begin n_err++; $display("FAIL drop_seq: at %0d got %h want %h", d, got_q[d], exp_q[d]); end
    endtask

    task automatic test_game_over();
        int d;
        game_over = 1'b1;
        model_frame(1'b1);
        run_frame(1, -1, 1'b1, 8000);
        game_over = 1'b0;
        n_vec++; if (got_q[$] !== mk(55, 95, 6)) begin n_err++; $display("FAIL go_colour: got %h want %h", got_q[$], mk(55, 95, 6)); end
        n_vec++; if (hold_err != 0) begin n_err++; $display("FAIL go_hold: got %0d unstable cycles want 0", hold_err); end
        d = first_diff();
        n_vec++; if (d >= 0) begin n_err++; $display("FAIL go_seq: at %0d got %h want %h", d, got_q[d], exp_q[d]); end
    endtask

    task automatic test_reset_mid_erase();
        int d;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        n_vec++; if ({plot, colour} !== 4'b1000) begin n_err++; $display("FAIL abort_in_erase: got plot/colour %b want 1000", {plot, colour}); end
        resetn = 1'b0;
        @(negedge clk); #1;
        n_vec++; if (plot !== 1'b0) begin n_err++; $display("FAIL abort_plot: got %b want 0", plot); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        resetn = 1'b1;
        model_reset();
        model_frame(1'b0);
        run_frame(0, -1, 1'b0, 3000);
        n_vec++; if (n_acc != 704) begin n_err++; $display("FAIL abort_next_count: got %0d want 704", n_acc); end
        d = first_diff();
        n_vec++; if (d >= 0) begin n_err++; $display("FAIL abort_seq: at %0d got %h want %h", d, got_q[d], exp_q[d]); end
    endtask

    task automatic test_clip();
        int d, m2;
        do_reset();
        mountain2_x = 10'd630; mountain2_y = 10'd470;
        model_frame(1'b0);
        run_frame(0, -1, 1'b0, 3000);
        m2 = 0;
        foreach (got_q[i]) if (got_q[i][21:12] >= 10'd630 && got_q[i][2:0] == 3'b010) m2++;
        n_vec++; if (n_acc != 548) begin n_err++; $display("FAIL clip_count: got %0d want 548", n_acc); end
        n_vec++; if (m2 != 100) begin n_err++; $display("FAIL clip_m2: got %0d want 100", m2); end
        d = first_diff();
        n_vec++; if (d >= 0) begin n_err++; $display("FAIL clip_seq: at %0d got %h want %h", d, got_q[d], exp_q[d]); end
    endtask

    task automatic test_random_frames();
        int d;
        for (int f = 0; f < 4; f++) begin
            plane_y     = 10'($urandom_range(0, 500));
            lava_x      = 10'($urandom_range(0, 660));
            lava_y      = 10'($urandom_range(0, 500));
            mountain1_x = 10'($urandom_range(0, 660));
            mountain1_y = 10'($urandom_range(0, 500));
            mountain2_x = 10'($urandom_range(600, 1023));
            mountain2_y = 10'($urandom_range(0, 1023));
            game_over   = 1'($urandom_range(0, 1));
            model_frame(game_over);
            run_frame(1, -1, 1'b0, 8000);
            n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL rand_done[%0d]: got %0d want 1", f, done_cnt); end
            d = first_diff();
            n_vec++; if (d >= 0) begin n_err++; $display("FAIL rand_seq[%0d]: at %0d got %h want %h", f, d, got_q[d], exp_q[d]); end
        end
        game_over = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_second_frame();
        test_stall();
        test_frame_drop();
        test_game_over();
        test_reset_mid_erase();
        test_clip();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "bench time limit reached");
    end

endmodule
`default_nettype wire
